// File: rtl/dmem_host_port_if.sv
// Host-link and DatMem port bundle for dmem_host_port.
// slave = the port block itself; master = host link plus the memory it fronts.
interface dmem_host_port_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_sel;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;

    modport slave (
        input  in_valid, in_data, out_ready, mem_rdat,
        output in_ready, out_valid, out_data, mem_sel, mem_wen, mem_addr, mem_wdat
    );

    modport master (
        output in_valid, in_data, out_ready, mem_rdat,
        input  in_ready, out_valid, out_data, mem_sel, mem_wen, mem_addr, mem_wdat
    );
endinterface

// File: rtl/dmem_host_port.sv
// Loads a DatMem block from the host, runs the core until Done/timeout, then drains a result window.
// Latency: load write same cycle as handshake; drain has one entry cycle, then one byte per cycle.
// Backpressure: in_ready only in LOAD; the drain output register holds steady while out_ready is low.
module dmem_host_port #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    dmem_host_port_if.slave   bus,
    output logic              cpu_reset,
    input  logic              cpu_done,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       run_cycles
);
    localparam int MAXLEN = (LOAD_LEN > RES_LEN) ? LOAD_LEN : RES_LEN;
    localparam int CW     = (MAXLEN > 0) ? $clog2(MAXLEN + 1) : 1;
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0] RES_END   = CW'(RES_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   run_nxt;
    logic          tmo_q, tmo_nxt;
    logic          ov_q, ov_nxt;
    logic [DW-1:0] od_q, od_nxt;
    logic [AW-1:0] load_addr, res_addr;
    logic          done_seen, expire;

    assign load_addr = AW'(LOAD_BASE) + AW'(cnt);
    // While draining, cnt already points at the byte after the one held in od_q.
    assign res_addr  = AW'(RES_BASE) + AW'(cnt);
    assign done_seen = cpu_done && (run_cycles != 16'd0);
    assign expire    = (TIMEOUT != 0) && ((32'(run_cycles) + 32'd1) == 32'(TIMEOUT));

    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign timeout       = tmo_q;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        run_nxt      = run_cycles;
        tmo_nxt      = tmo_q;
        ov_nxt       = ov_q;
        od_nxt       = od_q;
        bus.in_ready = 1'b0;
        bus.mem_sel  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdat = bus.in_data;
        cpu_reset    = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                done = (state == S_FIN);
                if (start) begin
                    cnt_nxt   = '0;
                    tmo_nxt   = 1'b0;
                    run_nxt   = 16'd0;
                    state_nxt = (LOAD_LEN == 0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                // Gated by Reset so a reset cycle never lands a write in DatMem.
                bus.in_ready = Reset;
                bus.mem_addr = load_addr;
                bus.mem_wen  = bus.in_valid && Reset;
                if (bus.in_valid) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LOAD_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                bus.mem_sel = 1'b1;
                cpu_reset   = 1'b0;
                run_nxt     = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
                if (done_seen || expire) begin
                    tmo_nxt   = !done_seen;
                    cnt_nxt   = '0;
                    state_nxt = (RES_LEN == 0) ? S_FIN : S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy         = 1'b1;
                bus.mem_addr = res_addr;
                if (!ov_q) begin
                    od_nxt  = bus.mem_rdat;
                    ov_nxt  = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end else if (bus.out_ready) begin
                    if (cnt == RES_END) begin
                        ov_nxt    = 1'b0;
                        state_nxt = S_FIN;
                    end else begin
                        od_nxt  = bus.mem_rdat;
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            run_cycles <= 16'd0;
            tmo_q      <= 1'b0;
            ov_q       <= 1'b0;
            od_q       <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            run_cycles <= run_nxt;
            tmo_q      <= tmo_nxt;
            ov_q       <= ov_nxt;
            od_q       <= od_nxt;
        end
    end
endmodule

// File: tb/tb_dmem_host_port.sv
// Directed bench for dmem_host_port: one instance for load/run/drain/timeout/reset, one for address wrap.
module tb_dmem_host_port;
    logic        Clk;
    logic        Reset;
    logic        start_a, start_b;
    logic        cpu_done_a, cpu_done_b;
    logic        cpu_reset_a, cpu_reset_b;
    logic        busy_a, busy_b, done_a, done_b, timeout_a, timeout_b;
    logic [15:0] run_cycles_a, run_cycles_b;
    logic        core_wen;
    logic [7:0]  core_addr, core_wdat;
    logic [7:0]  mem_a [256] = '{default: 8'h00};
    logic [7:0]  mem_b [256] = '{default: 8'h00};
    int          n_chk  = 0;
    int          n_pass = 0;

    dmem_host_port_if #(.AW(8), .DW(8)) ifa ();
    dmem_host_port_if #(.AW(8), .DW(8)) ifb ();

    dmem_host_port #(
        .AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(4),
        .RES_BASE(64), .RES_LEN(4), .TIMEOUT(16)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .start(start_a), .bus(ifa),
        .cpu_reset(cpu_reset_a), .cpu_done(cpu_done_a), .busy(busy_a),
        .done(done_a), .timeout(timeout_a), .run_cycles(run_cycles_a)
    );

    dmem_host_port #(
        .AW(8), .DW(8), .LOAD_BASE(250), .LOAD_LEN(8),
        .RES_BASE(0), .RES_LEN(0), .TIMEOUT(0)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .start(start_b), .bus(ifb),
        .cpu_reset(cpu_reset_b), .cpu_done(cpu_done_b), .busy(busy_b),
        .done(done_b), .timeout(timeout_b), .run_cycles(run_cycles_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // DatMem models: the port block writes when it owns the port, the model core otherwise.
    always @(posedge Clk) begin
        if (!ifa.mem_sel && ifa.mem_wen)
            mem_a[ifa.mem_addr] <= ifa.mem_wdat;
        else if (ifa.mem_sel && core_wen)
            mem_a[core_addr] <= core_wdat;
    end
    always @(posedge Clk) begin
        if (!ifb.mem_sel && ifb.mem_wen)
            mem_b[ifb.mem_addr] <= ifb.mem_wdat;
    end
    assign ifa.mem_rdat = mem_a[ifa.mem_addr];
    assign ifb.mem_rdat = mem_b[ifb.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [7:0] t1_bytes [4];
        logic       rdy_pat [7];
        int         k;
        int         n;
        t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        Reset = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        cpu_done_a = 1'b0; cpu_done_b = 1'b0;
        core_wen = 1'b0; core_addr = 8'h00; core_wdat = 8'h00;
        ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.out_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_timeout", timeout_a, 0);
        chk("rst_run_cycles", run_cycles_a, 0);
        chk("rst_cpu_reset", cpu_reset_a, 1);
        chk("rst_mem_sel", ifa.mem_sel, 0);
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_mem_wen", ifa.mem_wen, 0);
        chk("rst_mem_addr", ifa.mem_addr, 0);

        // T1: load 11,22,33,44 with gaps; start pulsed during LOAD must be ignored
        Reset = 1'b1;
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t1_in_ready", ifa.in_ready, 1);
        chk("t1_busy", busy_a, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1 || i == 2) begin
                ifa.in_valid = 1'b0;
                start_a = (i == 2);
                #1;
                chk("t1_gap_wen", ifa.mem_wen, 0);
                step();
                start_a = 1'b0;
            end
            ifa.in_valid = 1'b1;
            ifa.in_data  = t1_bytes[i];
            #1;
            chk("t1_wen", ifa.mem_wen, 1);
            chk("t1_addr", ifa.mem_addr, 32'(i));
            chk("t1_wdat", ifa.mem_wdat, t1_bytes[i]);
            step();
            ifa.in_valid = 1'b0;
        end
        chk("t1_run_mem_sel", ifa.mem_sel, 1);
        chk("t1_run_cpu_reset", cpu_reset_a, 0);
        chk("t1_run_in_ready", ifa.in_ready, 0);
        chk("t1_mem0", mem_a[0], 8'h11);
        chk("t1_mem1", mem_a[1], 8'h22);
        chk("t1_mem2", mem_a[2], 8'h33);
        chk("t1_mem3", mem_a[3], 8'h44);

        // T2: core writes results, Done in cycle 1 is ignored, Done in cycle 10 ends the run
        for (int c = 1; c <= 10; c++) begin
            cpu_done_a = (c == 1) || (c == 10);
            core_wen   = (c >= 2) && (c <= 5);
            core_addr  = 8'(64 + c - 2);
            core_wdat  = 8'(8'hA0 + c - 2);
            step();
            if (c == 1) begin
                chk("t2_done_ignored", ifa.mem_sel, 1);
                chk("t2_rc1", run_cycles_a, 1);
            end
        end
        cpu_done_a = 1'b0;
        core_wen   = 1'b0;
        chk("t2_run_cycles", run_cycles_a, 10);
        chk("t2_cpu_reset", cpu_reset_a, 1);
        chk("t2_mem_sel", ifa.mem_sel, 0);
        chk("t2_timeout", timeout_a, 0);
        chk("t2_entry_valid", ifa.out_valid, 0);
        chk("t2_entry_addr", ifa.mem_addr, 64);
        step();

        // T3: out_ready 1,0,0,1,0,1,1 -> four bytes, each once, held during stalls
        k = 0;
        for (int j = 0; j < 7; j++) begin
            ifa.out_ready = rdy_pat[j];
            chk("t3_valid", ifa.out_valid, 1);
            chk("t3_data", ifa.out_data, 32'(8'hA0 + k));
            step();
            if (rdy_pat[j]) k++;
        end
        ifa.out_ready = 1'b0;
        chk("t3_bytes", k, 4);
        chk("t3_valid_off", ifa.out_valid, 0);
        chk("t3_done", done_a, 1);
        chk("t3_busy", busy_a, 0);
        chk("t3_cpu_reset", cpu_reset_a, 1);
        chk("t3_rc_hold", run_cycles_a, 10);

        // T4: no Done -> timeout after 16 RUN cycles, drain still runs
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t4_done_clr", done_a, 0);
        chk("t4_rc_clr", run_cycles_a, 0);
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 8'(i + 1);
            step();
        end
        ifa.in_valid = 1'b0;
        n = 0;
        while (ifa.mem_sel && n < 40) begin
            step();
            n++;
        end
        chk("t4_run_len", n, 16);
        chk("t4_timeout", timeout_a, 1);
        chk("t4_run_cycles", run_cycles_a, 16);
        ifa.out_ready = 1'b1;
        chk("t4_entry_valid", ifa.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_valid", ifa.out_valid, 1);
            chk("t4_data", ifa.out_data, 32'(8'hA0 + i));
        end
        step();
        ifa.out_ready = 1'b0;
        chk("t4_done", done_a, 1);
        chk("t4_timeout_hold", timeout_a, 1);

        // T6: reset in RUN cycle 3 aborts; reset during a LOAD handshake writes nothing
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t6_timeout_clr", timeout_a, 0);
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 8'(i + 5);
            step();
        end
        ifa.in_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        chk("t6_busy", busy_a, 0);
        chk("t6_cpu_reset", cpu_reset_a, 1);
        chk("t6_mem_sel", ifa.mem_sel, 0);
        chk("t6_rc", run_cycles_a, 0);
        Reset = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'hEE;
        Reset = 1'b0;
        #1;
        chk("t6_no_wen", ifa.mem_wen, 0);
        step();
        ifa.in_valid = 1'b0;
        Reset = 1'b1;
        chk("t6_mem0", mem_a[0], 8'h05);
        chk("t6_idle_in_ready", ifa.in_ready, 0);

        // T5: LOAD_BASE 250, 8 bytes wrap to 0,1; RES_LEN 0 goes straight to FIN
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = 8'(8'h50 + i);
            #1;
            chk("t5_addr", ifb.mem_addr, 32'((250 + i) % 256));
            step();
        end
        ifb.in_valid = 1'b0;
        chk("t5_mem250", mem_b[250], 8'h50);
        chk("t5_mem255", mem_b[255], 8'h55);
        chk("t5_mem0", mem_b[0], 8'h56);
        chk("t5_mem1", mem_b[1], 8'h57);
        chk("t5_run", ifb.mem_sel, 1);
        cpu_done_b = 1'b1;
        step();
        chk("t5_first_ignored", ifb.mem_sel, 1);
        step();
        cpu_done_b = 1'b0;
        chk("t5_done", done_b, 1);
        chk("t5_rc", run_cycles_b, 2);
        chk("t5_timeout", timeout_b, 0);
        chk("t5_no_out", ifb.out_valid, 0);
        chk("t5_busy", busy_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
